// File: rtl/sprite_rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter_if
// Requester-side bus of the sprite ROM arbiter.
//   req       : per-requester read request (level, held until granted)
//   req_addr  : packed ROM addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt       : one-hot, one-cycle grant pulse
//   rd_valid  : one-hot, one-cycle read-data valid pulse
//   rd_data   : read data shared by all requesters, qualified by rd_valid
// Modports: master = pixel-pipeline requesters, slave = arbiter.
// -----------------------------------------------------------------------------
interface sprite_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;

    modport master (
        output req,
        output req_addr,
        input  gnt,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  req,
        input  req_addr,
        output gnt,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
// Shares one single-port sprite/board ROM read port between NUM_REQ
// pixel-pipeline requesters in the VGA clock domain. One winner per cycle
// drives the registered ROM address/enable; the returned word is delivered
// to the winner ROM_LAT+1 edges after the grant with a one-hot rd_valid.
//
// Ports:
//   vga_clk   : sole clock, all state on the rising edge
//   rst       : asynchronous, active-high reset (drops in-flight reads)
//   bus       : requester bus (sprite_rom_arbiter_if.slave)
//   rom_addr  : registered ROM address
//   rom_en    : registered ROM read enable
//   rom_q     : ROM read data, valid ROM_LAT cycles after rom_en is sampled
//
// Build option:
//   SPRITE_ARB_FIXED_PRIO_EN defined -> fixed priority, lowest index wins.
//   undefined (default)              -> round-robin starting after the
//                                       last winner.
// -----------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                 vga_clk,
    input  logic                 rst,
    sprite_rom_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0]    rom_addr,
    output logic                 rom_en,
    input  logic [DATA_W-1:0]    rom_q
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] elig_s;
    logic               win_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [NUM_REQ-1:0] win_oh_s;

    logic [NUM_REQ-1:0] gnt_r;
    logic [ADDR_W-1:0]  rom_addr_r;
    logic               rom_en_r;
    logic [NUM_REQ-1:0] rd_valid_r;
    logic [DATA_W-1:0]  rd_data_r;

    // One-hot requester id per ROM read in flight; stage 0 loads with rom_en.
    logic [NUM_REQ-1:0] tag_r [0:ROM_LAT];

`ifndef SPRITE_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   last_r;
`endif

    // Winner selection; a requester granted on the previous edge is masked so
    // a req still held during its gnt cycle is not served twice.
    always_comb begin
        int cand;
        cand      = 0;
        elig_s    = bus.req & ~gnt_r;
        win_s     = 1'b0;
        win_idx_s = '0;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        // Scan from the top so the lowest eligible index is written last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand      = i;
            win_s     = elig_s[cand] ? 1'b1 : win_s;
            win_idx_s = elig_s[cand] ? IDX_W'(cand) : win_idx_s;
        end
`else
        // Scan offsets from farthest (last itself) to nearest (last+1) so the
        // first eligible requester after last is written last and wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand      = int'(last_r) + k;
            cand      = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
            win_s     = elig_s[cand] ? 1'b1 : win_s;
            win_idx_s = elig_s[cand] ? IDX_W'(cand) : win_idx_s;
        end
`endif
        win_oh_s = win_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s)
                         : {NUM_REQ{1'b0}};
    end

    // Grant pulse, ROM request registers and round-robin pointer.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            gnt_r      <= '0;
            rom_en_r   <= 1'b0;
            rom_addr_r <= '0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            last_r     <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            gnt_r    <= win_oh_s;
            rom_en_r <= win_s;
            if (win_s) begin
                rom_addr_r <= bus.req_addr[win_idx_s*ADDR_W +: ADDR_W];
`ifndef SPRITE_ARB_FIXED_PRIO_EN
                last_r     <= win_idx_s;
`endif
            end else begin
                rom_addr_r <= rom_addr_r;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
                last_r     <= last_r;
`endif
            end
        end
    end

    // Requester-id shift register aligned with the ROM read latency.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= ROM_LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            tag_r[0] <= win_oh_s;
            for (int i = 1; i <= ROM_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Read-data return: capture rom_q when the tail of the tag pipe is live.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            rd_valid_r <= '0;
            rd_data_r  <= '0;
        end else begin
            if (|tag_r[ROM_LAT]) begin
                rd_valid_r <= tag_r[ROM_LAT];
                rd_data_r  <= rom_q;
            end else begin
                rd_valid_r <= '0;
                rd_data_r  <= rd_data_r;
            end
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = rd_data_r;
    assign rom_addr     = rom_addr_r;
    assign rom_en       = rom_en_r;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_rom_arbiter
// Directed plus randomized stimulus for sprite_rom_arbiter. A behavioural
// model (integer round-robin search, queue of pending reads with due cycle)
// predicts every output each cycle; directed steps add constant expectations.
// -----------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

    localparam int N   = 4;
    localparam int AW  = 10;
    localparam int DW  = 4;
    localparam int LAT = 1;

    logic          vga_clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rom_addr;
    logic          rom_en;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] rom_pipe [0:LAT-1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
        .vga_clk  (vga_clk),
        .rst      (rst),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_en   (rom_en),
        .rom_q    (rom_q)
    );

    // ROM model: word = low nibble of the address, LAT cycles after rom_en.
    always @(posedge vga_clk) begin
        rom_pipe[0] <= rom_en ? rom_addr[3:0] : rom_pipe[0];
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    logic [N-1:0]  m_gnt;
    logic [N-1:0]  m_rdv;
    logic [AW-1:0] m_addr;
    logic          m_en;
    logic [DW-1:0] m_rdd;
    int            m_last;

    task automatic model_reset();
        m_gnt  = '0;
        m_rdv  = '0;
        m_addr = '0;
        m_en   = 1'b0;
        m_rdd  = '0;
        m_last = N - 1;
        pend.delete();
    endtask

    task automatic model_edge();
        logic [N-1:0] elig;
        int w;
        rd_t r;
        elig = bus.req & ~m_gnt;
        w = -1;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (w < 0 && elig[i]) w = i;
`else
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (w < 0 && elig[idx]) w = idx;
        end
`endif
        if (w >= 0) begin
            m_gnt  = N'(1) << w;
            m_addr = bus.req_addr[w*AW +: AW];
            m_en   = 1'b1;
            m_last = w;
            r.due  = cyc + LAT + 1;
            r.id   = w;
            r.data = m_addr[3:0];
            pend.push_back(r);
        end else begin
            m_gnt = '0;
            m_en  = 1'b0;
        end
        m_rdv = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            m_rdv = N'(1) << pend[0].id;
            m_rdd = pend[0].data;
            void'(pend.pop_front());
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model at the edge, compare everything 1 time unit later.
    task automatic tick();
        @(posedge vga_clk);
        cyc++;
        if (!rst) model_edge();
        #1;
        chk("gnt",      32'(bus.gnt),      32'(m_gnt));
        chk("rom_en",   32'(rom_en),       32'(m_en));
        chk("rom_addr", 32'(rom_addr),     32'(m_addr));
        chk("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
        chk("rd_data",  32'(bus.rd_data),  32'(m_rdd));
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a);
        bus.req[i] = 1'b1;
        bus.req_addr[i*AW +: AW] = a;
    endtask

    initial begin
        int exp_ord [8];
        int n_gnt;
        logic saw1;
        logic [N-1:0] prev_g;

        rst          = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        model_reset();

        // Reset state
        #12;
        chk("rst_gnt",      32'(bus.gnt),      32'h0);
        chk("rst_rom_en",   32'(rom_en),       32'h0);
        chk("rst_rom_addr", 32'(rom_addr),     32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_rd_data",  32'(bus.rd_data),  32'h0);
        @(posedge vga_clk);
        #1;
        rst = 1'b0;

        // Single request from requester 2
        set_req(2, 10'h123);
        tick();
        chk("t1_gnt",  32'(bus.gnt), 32'h4);
        chk("t1_addr", 32'(rom_addr), 32'h123);
        bus.req[2] = 1'b0;
        tick();
        chk("t1_no_rdv", 32'(bus.rd_valid), 32'h0);
        tick();
        chk("t1_rdv",  32'(bus.rd_valid), 32'h4);
        chk("t1_rdd",  32'(bus.rd_data),  32'h3);

        // All four held continuously
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        exp_ord = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_ord = '{3, 0, 1, 2, 3, 0, 1, 2};
`endif
        for (int i = 0; i < N; i++) set_req(i, AW'(10'h2A0 + 10'(i * 5 + 1)));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("all_order", 32'(bus.gnt), 32'(N'(1) << exp_ord[i]));
            chk("all_en",    32'(rom_en),  32'h1);
        end
        bus.req = '0;
        for (int i = 0; i < 3; i++) tick();

        // Requester 0 alone for 6 cycles
        set_req(0, 10'h0F7);
        n_gnt = 0;
        prev_g = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.gnt[0]) n_gnt++;
            chk("solo_no_b2b", 32'(bus.gnt[0] & prev_g[0]), 32'h0);
            prev_g = bus.gnt;
        end
        chk("solo_count", 32'(n_gnt), 32'd3);
        bus.req = '0;
        for (int i = 0; i < 3; i++) tick();

        // Request 1 withdrawn before grant while 3 wins
        set_req(2, 10'h055);
        tick();
        bus.req = '0;
        tick();
        set_req(1, 10'h111);
        set_req(3, 10'h333);
        tick();
`ifndef SPRITE_ARB_FIXED_PRIO_EN
        chk("wd_gnt3", 32'(bus.gnt), 32'h8);
`endif
        bus.req = '0;
        saw1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            saw1 = saw1 | bus.gnt[1] | bus.rd_valid[1];
`endif
        end
        chk("wd_no_req1", 32'(saw1), 32'h0);

        // Asynchronous reset mid-cycle with reads in flight
        for (int i = 0; i < N; i++) set_req(i, AW'(10'h1F0 + 10'(i + 9)));
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_gnt",      32'(bus.gnt),      32'h0);
        chk("arst_rom_en",   32'(rom_en),       32'h0);
        chk("arst_rom_addr", 32'(rom_addr),     32'h0);
        chk("arst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("arst_rd_data",  32'(bus.rd_data),  32'h0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("arst_first_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        for (int i = 0; i < 3; i++) tick();

        // Randomized traffic: req held until granted, occasional withdrawal
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if (bus.gnt[i]) begin
                        if ($urandom_range(1, 0) == 1) bus.req[i] = 1'b0;
                        else bus.req_addr[i*AW +: AW] = AW'($urandom);
                    end else if ($urandom_range(15, 0) == 0) begin
                        bus.req[i] = 1'b0;
                    end
                end else if ($urandom_range(1, 0) == 1) begin
                    set_req(i, AW'($urandom));
                end
            end
            tick();
        end
        bus.req = '0;
        for (int i = 0; i < LAT + 3; i++) tick();
        chk("drain_empty", 32'(pend.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one single-port sprite/board ROM read port between up to NUM_REQ pixel-pipeline requesters (board background, Fireboy, Watergirl, doors/gems). Requesters issue address requests with a req/gnt handshake; the block picks one winner per cycle, drives the ROM address and enable, and routes the returned ROM word back to the winner with a one-hot valid. It sits between the per-sprite draw logic and the ROM, in the VGA clock domain.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 10, ROM address width
- DATA_W, 4, ROM word width (palette index)
- ROM_LAT, 1, cycles from rom_en high at a rising edge to rom_q valid (1..3)
- vga_clk  in  1  sole clock; all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester read request, level
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot grant pulse, one cycle
- rom_addr  out  ADDR_W  registered ROM address
- rom_en  out  1  registered ROM read enable
- rom_q  in  DATA_W  ROM read data
- rd_valid  out  NUM_REQ  one-hot read-data valid pulse
- rd_data  out  DATA_W  registered read data, shared by all requesters

## Operation
- Each cycle, eligible set = req & ~gnt (requester granted this cycle is masked so a held req is not granted twice).
- Round-robin: search starts at index last+1 (mod NUM_REQ), first eligible wins; last updates to winner on grant. With no eligible requester, last holds.
- On a win at edge T: gnt[w]<=1, rom_addr<=req_addr[w], rom_en<=1; otherwise gnt<=0, rom_en<=0, rom_addr holds.
- Requester keeps req and req_addr stable until it sees gnt; may drop req or change address in the gnt cycle. Max one grant per requester every 2 cycles; different requesters may be granted back-to-back.
- Tag pipeline: ROM_LAT+1 stage shift register of (valid, one-hot id) launched with rom_en; at its tail rd_data<=rom_q and rd_valid<=id, else rd_valid<=0, rd_data holds.
- Reset (any time, including mid-transaction): gnt=0, rom_en=0, rom_addr=0, rd_valid=0, rd_data=0, last=NUM_REQ-1 (requester 0 wins first), tag pipeline cleared; in-flight reads are dropped, never delivered.
- Requests withdrawn before grant are simply not served; no error state.

## Timing
- req high before edge T -> gnt and rom_addr/rom_en valid after T (1 cycle).
- rd_valid/rd_data after edge T+ROM_LAT+1; total req-to-data latency ROM_LAT+2 cycles.
- Throughput: one ROM read per cycle when ≥2 requesters active.
- Exactly one rd_valid per gnt, in grant order; at most one bit of gnt and of rd_valid set.
- Simultaneous Reset deassertion and req: first grant on the first edge with Reset low.

## Configuration
- SPRITE_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins among eligible; last pointer unused (starvation of high indices permitted, intended for board-has-priority builds).
- Undefined (default): round-robin as above.

## Test plan
- Reset, single req[2]=1, addr 0x123, ROM model returns addr[3:0] with ROM_LAT=1 -> gnt=4'b0100 one cycle later, rom_addr=0x123, rd_valid=4'b0100, rd_data=4'h3 three cycles after req.
- All four req held continuously, distinct addresses -> grants 0,1,2,3,0,... one per cycle, rom_en high every cycle, rd_valid follows same order 2 cycles after each gnt.
- req[0] alone held high for 6 cycles -> gnt[0] pulses every other cycle (3 grants), never two consecutive.
- Reset asserted asynchronously mid-cycle with 2 reads in flight -> all outputs 0 immediately, no rd_valid after release, next grant goes to requester 0.
- req[1] raised then dropped before grant while req[3] wins -> no gnt[1], no rd_valid[1].
- With SPRITE_ARB_FIXED_PRIO_EN, req[0] and req[3] held -> gnt alternates only when req[0] is masked: 0,3,0,3; with req[0],req[1] held -> 0,1,0,1, req[3] starves.
